seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised multi-digit 7-segment scanner for the board display path.
- Takes a packed hex word, per-digit decimal points and enables, and time-multiplexes NUM_DIGITS common-anode digits.
- Adds a tear-free shadow load, leading-zero blanking, 16-level PWM brightness and a frame-done strobe.
- Sits between the datapath debug/output registers and the board anode/cathode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- TICK_DIV, 100000, clk cycles per digit slot; must be a multiple of 16, minimum 16.
- DIV_W, 17, prescaler width; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, and digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 forces that digit dark.
- blank_lz  in  1  leading-zero blanking enable.
- brightness  in  4  PWM level 0..15.
- update  in  1  single-cycle strobe; loads data/dp_in into shadow registers.
- anode  out  NUM_DIGITS  digit selects, active-low.
- catode  out  8  segments, active-low; bit7 = dp, bits6..0 = g..a.
- frame_done  out  1  one-cycle pulse per completed scan frame.

Behaviour:
- Clock and reset: single clock domain clk. reset is asynchronous, active-high.
- Reset values:
  - prescaler = 0, idx = 0, shadow data = 0, shadow dp = 0.
  - anode = all 1s, catode = 8'hFF, frame_done = 0.
- Shadow load:
  - On a cycle with update = 1, data and dp_in are registered into shadow regs.
  - The display uses only shadow regs, so a change on data without update has no visible effect.
  - update asserted in the same cycle as a slot tick: the new value is loaded, and the next slot uses it.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (prescaler == TICK_DIV-1).
- Digit index:
  - On tick, idx increments; NUM_DIGITS-1 wraps to 0.
  - frame_done is registered high for exactly the cycle after a tick where idx wrapped.
- PWM:
  - SUB = TICK_DIV/16.
  - Slot is lit while prescaler < (brightness+1)*SUB.
  - brightness 15 = full slot; brightness 0 = 1/16 slot.
  - A brightness change takes effect on the next cycle with no glitch beyond the comparison.
- Leading-zero blanking:
  - Digit i (i >= 1) is zero-blanked when blank_lz = 1 and shadow nibbles NUM_DIGITS-1 down to i are all 0.
  - Digit 0 is never zero-blanked, so 0x0000 shows "0".
  - dp on a blanked digit is also suppressed.
- Digit dark condition: digit_en[idx] = 0, OR zero-blanked, OR outside the PWM window.
- When dark: anode = all 1s, catode = 8'hFF.
- When lit:
  - anode = ~(1 << idx).
  - catode[6:0] = active-low hex pattern of the nibble.
  - catode[7] = ~dp.
- Latency: anode/catode are registered, i.e. one clk after the prescaler/idx state that produced them. They change together, so a wrong digit is never driven.
- Hex patterns use the standard 0-9, A, b, C, d, E, F glyphs.
- Mid-operation reset: immediate dark outputs. The scan restarts from idx 0 with shadow cleared.

Decomposition:
- Shared include/package holds:
  - SEG_BLANK = 8'hFF.
  - The 16 active-low glyph localparams.
  - The anode polarity constant.
- One sub-module, hex_seg_decoder: combinational 4-bit nibble -> 7-bit active-low segments.
- The remaining logic stays in seg_scan_display:
  - prescaler
  - idx
  - shadow registers
  - blanking
  - PWM
  - output registers

Test Plan:
1. Reset and frame strobe (TICK_DIV=16, NUM_DIGITS=4):
   - Assert reset mid-scan -> anode = 4'hF, catode = 8'hFF immediately.
   - After release, first lit digit is idx 0.
   - frame_done pulses every 64 cycles.
2. Digit glyphs: update with data = 16'h1A3F, dp_in = 4'b0100, brightness = 15, all enabled.
   - Slot 0: anode = 4'b1110, catode = 8'h8E (F).
   - Slot 2: anode = 4'b1011, catode = 8'h08 (A with dp).
3. Shadow tearing: change data to 16'h2222 without update -> display still shows 1A3F.
   - Pulse update -> next slot shows 2.
4. Leading-zero blanking, blank_lz = 1:
   - data = 16'h0050 -> digits 3 and 2 dark (anode = all 1s in those slots); digits 1 and 0 show 5 and 0.
   - data = 16'h0000 -> only digit 0 lit, showing "0" (catode = 8'hC0).
5. Brightness:
   - brightness = 3 -> each slot lit for exactly 4 of 16 cycles.
   - brightness = 0 -> lit for 1 cycle.
   - digit_en = 4'b1101 -> slot 1 fully dark.
6. Simultaneous update and tick: load new data on the tick cycle -> the following slot uses the new nibble with no intermediate glyph.

Source files
------------

// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment display path:
// blank pattern, anode polarity and the active-low hex glyph set (bits 6..0 = g..a).
package seg_scan_display_pkg;

   localparam logic [7:0]  SEG_BLANK    = 8'hFF;
   localparam logic        ANODE_ACTIVE = 1'b0;
   localparam int unsigned PWM_LEVELS   = 16;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg_scan_display_hex_seg_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern (bits 6..0 = g..a).
module hex_seg_decoder
   import seg_scan_display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   // Glyph lookup
   always_comb begin
      seg_o = SEG_BLANK[6:0];
      case (nibble_i)
         4'h0:    seg_o = GLYPH_0;
         4'h1:    seg_o = GLYPH_1;
         4'h2:    seg_o = GLYPH_2;
         4'h3:    seg_o = GLYPH_3;
         4'h4:    seg_o = GLYPH_4;
         4'h5:    seg_o = GLYPH_5;
         4'h6:    seg_o = GLYPH_6;
         4'h7:    seg_o = GLYPH_7;
         4'h8:    seg_o = GLYPH_8;
         4'h9:    seg_o = GLYPH_9;
         4'hA:    seg_o = GLYPH_A;
         4'hB:    seg_o = GLYPH_B;
         4'hC:    seg_o = GLYPH_C;
         4'hD:    seg_o = GLYPH_D;
         4'hE:    seg_o = GLYPH_E;
         4'hF:    seg_o = GLYPH_F;
         default: seg_o = SEG_BLANK[6:0];
      endcase
   end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode 7-segment scanner with shadow load,
// leading-zero blanking, 16-level PWM brightness and a frame-done strobe.
module seg_scan_display
   import seg_scan_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 100000,
   parameter int DIV_W      = 17
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    blank_lz,
   input  logic [3:0]              brightness,
   input  logic                    update,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [7:0]              catode,
   output logic                    frame_done
);

   localparam int                IDX_W     = $clog2(NUM_DIGITS);
   localparam logic [DIV_W-1:0]  TICK_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W:0]    SUB       = (DIV_W+1)'(TICK_DIV / PWM_LEVELS);
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{~ANODE_ACTIVE}};

   logic [DIV_W-1:0]        prescaler_q, prescaler_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [7:0]              catode_q, catode_d;
   logic                    frame_done_q, frame_done_d;

   logic                    tick_s;
   logic [NUM_DIGITS-1:0]   zero_blank_s;
   logic [3:0]              cur_nib_s;
   logic [6:0]              cur_seg_s;
   logic [DIV_W:0]          pwm_limit_s;
   logic                    in_window_s;
   logic                    lit_s;
   logic [NUM_DIGITS-1:0]   digit_onehot_s;

   hex_seg_decoder u_dec (
      .nibble_i (cur_nib_s),
      .seg_o    (cur_seg_s)
   );

   // Prescaler, digit index, frame strobe and shadow load
   always_comb begin
      tick_s        = (prescaler_q == TICK_LAST);
      prescaler_d   = prescaler_q + DIV_W'(1);
      idx_d         = idx_q;
      frame_done_d  = 1'b0;
      shadow_data_d = shadow_data_q;
      shadow_dp_d   = shadow_dp_q;
      if (tick_s) begin
         prescaler_d  = '0;
         frame_done_d = (idx_q == IDX_LAST);
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         prescaler_d = prescaler_q + DIV_W'(1);
      end
      if (update) begin
         shadow_data_d = data;
         shadow_dp_d   = dp_in;
      end else begin
         shadow_data_d = shadow_data_q;
         shadow_dp_d   = shadow_dp_q;
      end
   end

   // Leading-zero mask: a digit blanks only if it and everything above it are zero
   always_comb begin
      logic upper_zero;
      upper_zero   = 1'b1;
      zero_blank_s = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         upper_zero      = upper_zero & (shadow_data_q[4*i +: 4] == 4'h0);
         zero_blank_s[i] = blank_lz & upper_zero & (i != 0);
      end
   end

   // Current-slot glyph, PWM window and registered pin values
   always_comb begin
      cur_nib_s      = shadow_data_q[{idx_q, 2'b00} +: 4];
      pwm_limit_s    = ((DIV_W+1)'(brightness) + (DIV_W+1)'(1)) * SUB;
      in_window_s    = ({1'b0, prescaler_q} < pwm_limit_s);
      lit_s          = digit_en[idx_q] & ~zero_blank_s[idx_q] & in_window_s;
      digit_onehot_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
      anode_d        = ANODE_OFF;
      catode_d       = SEG_BLANK;
      if (lit_s) begin
         anode_d  = ANODE_ACTIVE ? digit_onehot_s : ~digit_onehot_s;
         catode_d = {~shadow_dp_q[idx_q], cur_seg_s};
      end else begin
         anode_d  = ANODE_OFF;
         catode_d = SEG_BLANK;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler_q   <= '0;
         idx_q         <= '0;
         shadow_data_q <= '0;
         shadow_dp_q   <= '0;
         anode_q       <= ANODE_OFF;
         catode_q      <= SEG_BLANK;
         frame_done_q  <= 1'b0;
      end else begin
         prescaler_q   <= prescaler_d;
         idx_q         <= idx_d;
         shadow_data_q <= shadow_data_d;
         shadow_dp_q   <= shadow_dp_d;
         anode_q       <= anode_d;
         catode_q      <= catode_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign anode      = anode_q;
   assign catode     = catode_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomised cycle-level check of seg_scan_display against a slot/arithmetic reference model.
module tb_seg_scan_display;

   localparam int NUM_DIGITS = 4;
   localparam int TICK_DIV   = 16;
   localparam int DIV_W      = 5;

   logic                    clk;
   logic                    reset;
   logic [4*NUM_DIGITS-1:0] data;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    blank_lz;
   logic [3:0]              brightness;
   logic                    update;
   logic [NUM_DIGITS-1:0]   anode;
   logic [7:0]              catode;
   logic                    frame_done;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int lit_cnt = 0;
   int fd_cnt  = 0;
   logic [4*NUM_DIGITS-1:0] m_data = '0;
   logic [NUM_DIGITS-1:0]   m_dp   = '0;

   // Active-low g..a glyphs as they appear on a standard hex display
   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_scan_display #(
      .NUM_DIGITS (NUM_DIGITS),
      .TICK_DIV   (TICK_DIV),
      .DIV_W      (DIV_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data       (data),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .blank_lz   (blank_lz),
      .brightness (brightness),
      .update     (update),
      .anode      (anode),
      .catode     (catode),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: predict outputs from slot arithmetic, advance model, compare on the falling edge
   task automatic run_cycle();
      int p, ix;
      logic zb, lit;
      logic [3:0] nib;
      logic [NUM_DIGITS-1:0] one, e_anode;
      logic [7:0] e_cat;
      logic e_fd;
      @(posedge clk);
      p   = cyc % TICK_DIV;
      ix  = (cyc / TICK_DIV) % NUM_DIGITS;
      nib = m_data[4*ix +: 4];
      zb  = blank_lz && (ix != 0) && ((m_data >> (4*ix)) == 0);
      lit = digit_en[ix] && !zb && (p < (int'(brightness) + 1) * (TICK_DIV / 16));
      one = 1;
      e_anode = lit ? ~(one << ix) : '1;
      e_cat   = lit ? {~m_dp[ix], glyph[nib]} : 8'hFF;
      e_fd    = (p == TICK_DIV - 1) && (ix == NUM_DIGITS - 1);
      if (update) begin
         m_data = data;
         m_dp   = dp_in;
      end
      cyc++;
      @(negedge clk);
      check("anode", 32'(anode), 32'(e_anode));
      check("catode", 32'(catode), 32'(e_cat));
      check("frame_done", 32'(frame_done), 32'(e_fd));
      if (anode != '1) lit_cnt++;
      if (frame_done) fd_cnt++;
   endtask

   task automatic run_n(input int n);
      for (int k = 0; k < n; k++) run_cycle();
   endtask

   task automatic load(input logic [15:0] d, input logic [3:0] dp);
      data   = d;
      dp_in  = dp;
      update = 1'b1;
      run_cycle();
      update = 1'b0;
   endtask

   function automatic logic [15:0] rand_data();
      logic [15:0] d;
      for (int k = 0; k < 4; k++)
         d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      return d;
   endfunction

   initial begin
      reset = 1'b1; data = '0; dp_in = '0; digit_en = 4'hF; blank_lz = 1'b0;
      brightness = 4'd15; update = 1'b0;
      #1;
      check("rst_anode", 32'(anode), 32'h0000000F);
      check("rst_catode", 32'(catode), 32'h000000FF);
      check("rst_frame_done", 32'(frame_done), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cyc = 0;

      fd_cnt = 0;
      run_n(128);
      check("frame_count", 32'(fd_cnt), 32'd2);

      load(16'h1A3F, 4'b0100);
      run_n(64);
      data = 16'h2222;
      run_n(64);
      load(16'h2222, 4'b0000);
      run_n(64);

      blank_lz = 1'b1;
      load(16'h0050, 4'b1111);
      run_n(64);
      load(16'h0000, 4'b0000);
      run_n(64);
      blank_lz = 1'b0;

      brightness = 4'd3;
      load(16'h1111, 4'b0000);
      run_cycle();
      lit_cnt = 0;
      run_n(64);
      check("lit_bright3", 32'(lit_cnt), 32'd16);
      brightness = 4'd0;
      run_cycle();
      lit_cnt = 0;
      run_n(64);
      check("lit_bright0", 32'(lit_cnt), 32'd4);
      brightness = 4'd15;
      digit_en = 4'b1101;
      run_cycle();
      lit_cnt = 0;
      run_n(64);
      check("lit_en1101", 32'(lit_cnt), 32'd48);
      digit_en = 4'hF;

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < TICK_DIV && (cyc % TICK_DIV) != TICK_DIV - 1; k++) run_cycle();
         load(rand_data(), 4'($urandom_range(0, 15)));
         run_n(24);
      end

      run_n(37);
      #2 reset = 1'b1;
      #1;
      check("midrst_anode", 32'(anode), 32'h0000000F);
      check("midrst_catode", 32'(catode), 32'h000000FF);
      check("midrst_frame_done", 32'(frame_done), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc = 0; m_data = '0; m_dp = '0;
      run_n(40);

      for (int r = 0; r < 1500; r++) begin
         if ($urandom_range(0, 7) == 0) begin
            data  = rand_data();
            dp_in = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 31) == 0) brightness = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) digit_en = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom_range(0, 1));
         update = ($urandom_range(0, 9) == 0);
         run_cycle();
      end
      update = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
